bus_cycle_ctrl: RTL and testbench
=================================

Name: bus_cycle_ctrl

Overview:
- Machine-cycle sequencer for the 8085-style system bus.
- Accepts one bus-cycle request at a time from the CPU core: opcode fetch, memory read/write, I/O read/write.
- Generates T-states (T1, T2, TW, T3, T4) and the pin signals ALE, RDn, WRn, IOMn, S1, S0 and the multiplexed AD bus. Inserts wait states on READY.
- Arbitrates the bus against an external HOLD requester (DMA) between machine cycles.

Parameters:
- MAX_WAIT, 15: max consecutive wait states before abort; 0 = no timeout (waits forever).
- AW, 16: address width. Upper byte is driven on A_HI, lower byte is multiplexed on AD.

Ports:
- clk  in  1  system clock, all state changes on rising edge
- rst  in  1  synchronous active-high reset
- req_valid  in  1  core requests a machine cycle
- req_type  in  3  0=OF, 1=MR, 2=MW, 3=IOR, 4=IOW, 5-7 reserved
- req_addr  in  AW  cycle address
- req_wdata  in  8  write data (MW/IOW)
- req_ready  out  1  request accepted when req_valid & req_ready
- done  out  1  one-cycle pulse, cycle complete
- err  out  1  qualifies done: timeout or reserved type
- rdata  out  8  data latched at end of T3 (OF/MR/IOR), held until next read
- READY  in  1  slave ready, sampled in T2/TW
- HOLD  in  1  external bus request
- HLDA  out  1  bus granted
- ALE  out  1  address latch enable
- RDn  out  1  read strobe, active low
- WRn  out  1  write strobe, active low
- IOMn  out  1  1 = I/O, 0 = memory
- S1  out  1  status bit 1
- S0  out  1  status bit 0
- A_HI  out  AW-8  upper address
- AD_OUT  out  8  low address / write data
- AD_OE  out  1  AD drive enable
- AD_IN  in  8  AD bus input
- BUS_OE  out  1  enable for ALE/RDn/WRn/IOMn/A_HI pin drivers

Behaviour:
Reset:
- state=IDLE; ALE=0; RDn=1; WRn=1; IOMn=0; S1=S0=0; A_HI=0; AD_OUT=0; AD_OE=0; BUS_OE=1; HLDA=0; done=0; err=0; rdata=0; req_ready=0.
- rst mid-cycle aborts immediately: no done, strobes return high on the next edge.

States: IDLE, T1, T2, TW, T3, T4, HOLDST.

req_ready:
- = 1 in IDLE, and in the final T-state (T3 for 3-state types, T4 for OF), when HOLD=0. Otherwise 0.

Acceptance:
- On accept, req_type, req_addr and req_wdata are registered; next state is T1.
- Back-to-back cycles run with no idle state between them.
- Reserved type on accept: no bus activity. done=1, err=1 on the next cycle; state stays IDLE.

Status per type (IOMn, S1, S0):
- OF = 0,1,1
- MR = 0,1,0
- MW = 0,0,1
- IOR = 1,1,0
- IOW = 1,0,1
- Status is held from T1 through the last T-state. IDLE shows S1S0=00, IOMn holds its last value.

T-state outputs:
- T1: ALE=1; A_HI=addr[AW-1:8]; AD_OUT=addr[7:0]; AD_OE=1.
- T2: ALE=0; RDn=0 (read types) or WRn=0 (writes). Write: AD_OUT=wdata, AD_OE=1. Read: AD_OE=0.
  - READY=0 at T2 → TW; else → T3.
- TW: strobe and outputs unchanged. wait counter increments; READY=1 → T3.
  - Counter reaching MAX_WAIT (MAX_WAIT>0) with READY=0 → abort: strobes high next cycle, done=1 & err=1, state → IDLE (or HOLDST if HOLD=1).
- T3: strobe still low. Read types latch rdata<=AD_IN at the rising edge ending T3.
  - Non-OF: done=1 during T3.
  - OF → T4.
- T4 (OF only): strobes high, AD_OE=0, done=1.

Strobe pulse width: 2 + Nwait clocks. The strobe deasserts on the edge leaving T3.

Next state from IDLE or final T-state:
- HOLD=1 → HOLDST. HOLD has priority over req_valid.
- else accepted request → T1.
- else → IDLE.
- HOLD is never granted mid-cycle.

HOLDST:
- HLDA=1, BUS_OE=0, AD_OE=0, ALE=0.
- HOLD=0 → IDLE: HLDA drops, BUS_OE=1, one idle clock guaranteed before the next T1.

Other rules:
- done and err are one-cycle pulses. err is 0 whenever done=0.
- Wait counter width is clog2(MAX_WAIT+1); it clears in T1.

Test Plan:
- MR addr=0x2050, READY=1, AD_IN=0xA5 in T3 → T1..T3; ALE high 1 clk; RDn low 2 clks; IOMn,S1,S0=0,1,0; rdata=0xA5; done in T3.
- OF addr=0x0000, AD_IN=0x3E → 4 T-states; S1S0=11; done in T4; rdata=0x3E. Back-to-back MW 0x1000/0x55 follows with T1 on the next clock after T4.
- IOW addr=0x0080 data=0x7F, READY low for 2 T2/TW samples → 2 TW states; WRn low 4 clks; AD_OUT=0x7F during T2..T3; IOMn=1, S1S0=01.
- MR with READY stuck 0, MAX_WAIT=15 → 15 TW states, then done=1, err=1; RDn high afterwards; rdata unchanged.
- HOLD raised in T2 of MR → cycle completes; HLDA=1 the cycle after T3; BUS_OE=0; pending req_valid not accepted. HOLD drop → one IDLE, then T1.
- rst asserted in TW of MW → next edge: WRn=1, AD_OE=0, state IDLE, no done. Reserved type 6 → done=1, err=1, no ALE.

Source files
------------

// File: rtl/bus_cycle_ctrl_if.sv
// Core-side request handshake plus 8085-style bus pins for bus_cycle_ctrl.
// The slave modport is the sequencer's view; master is the core/board side.
interface bus_cycle_ctrl_if #(
    parameter int unsigned AW = 16
);
    logic          req_valid;
    logic [2:0]    req_type;
    logic [AW-1:0] req_addr;
    logic [7:0]    req_wdata;
    logic          req_ready;
    logic          done;
    logic          err;
    logic [7:0]    rdata;
    logic          READY;
    logic          HOLD;
    logic          HLDA;
    logic          ALE;
    logic          RDn;
    logic          WRn;
    logic          IOMn;
    logic          S1;
    logic          S0;
    logic [AW-9:0] A_HI;
    logic [7:0]    AD_OUT;
    logic          AD_OE;
    logic [7:0]    AD_IN;
    logic          BUS_OE;

    modport slave (
        input  req_valid, req_type, req_addr, req_wdata, READY, HOLD, AD_IN,
        output req_ready, done, err, rdata, HLDA, ALE, RDn, WRn, IOMn, S1, S0,
               A_HI, AD_OUT, AD_OE, BUS_OE
    );

    modport master (
        output req_valid, req_type, req_addr, req_wdata, READY, HOLD, AD_IN,
        input  req_ready, done, err, rdata, HLDA, ALE, RDn, WRn, IOMn, S1, S0,
               A_HI, AD_OUT, AD_OE, BUS_OE
    );
endinterface

// File: rtl/bus_cycle_ctrl.sv
// 8085-style machine-cycle sequencer: T-state generation, wait-state insertion
// with timeout, and HOLD/HLDA arbitration between machine cycles.
module bus_cycle_ctrl #(
    parameter int unsigned MAX_WAIT = 15,
    parameter int unsigned AW       = 16
) (
    input logic            clk,
    input logic            rst,
    bus_cycle_ctrl_if.slave bus
);

    localparam int unsigned WW = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;
    localparam logic [2:0] TyOf = 3'd0;
    localparam logic [2:0] TyMr = 3'd1;
    localparam logic [2:0] TyMw = 3'd2;
    localparam logic [2:0] TyIor = 3'd3;
    localparam logic [2:0] TyIow = 3'd4;

    typedef enum logic [2:0] {StIdle, StT1, StT2, StTw, StT3, StT4, StHold} state_e;

    state_e        state_q, state_d, next_free;
    logic [2:0]    type_q;
    logic [AW-1:0] addr_q;
    logic [7:0]    wdata_q;
    logic [WW-1:0] wait_q;
    logic [7:0]    rdata_q;
    logic          iomn_q;
    logic          errp_q, errp_d;

    logic is_of, is_rd, is_wr, final_t, can_accept, accept, reserved_req, timeout;

    assign is_of        = (type_q == TyOf);
    assign is_rd        = (type_q == TyOf) || (type_q == TyMr) || (type_q == TyIor);
    assign is_wr        = (type_q == TyMw) || (type_q == TyIow);
    assign final_t      = ((state_q == StT3) && !is_of) || (state_q == StT4);
    assign can_accept   = !rst && !bus.HOLD && ((state_q == StIdle) || final_t);
    assign accept       = can_accept && bus.req_valid;
    assign reserved_req = (bus.req_type > TyIow);
    assign timeout      = (MAX_WAIT > 0) &&
                          (({1'b0, wait_q} + (WW + 1)'(1)) == (WW + 1)'(MAX_WAIT));

    // Decision taken wherever a new machine cycle may begin; HOLD wins over a request.
    assign next_free = bus.HOLD ? StHold : (accept && !reserved_req) ? StT1 : StIdle;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            type_q  <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            wait_q  <= '0;
            rdata_q <= '0;
            iomn_q  <= 1'b0;
            errp_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            errp_q  <= errp_d;
            if (accept) begin
                type_q  <= bus.req_type;
                addr_q  <= bus.req_addr;
                wdata_q <= bus.req_wdata;
                if (!reserved_req) begin
                    iomn_q <= (bus.req_type == TyIor) || (bus.req_type == TyIow);
                end
            end
            if (state_q == StT1) begin
                wait_q <= '0;
            end else if (state_q == StTw) begin
                wait_q <= wait_q + WW'(1);
            end
            if ((state_q == StT3) && is_rd) begin
                rdata_q <= bus.AD_IN;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        errp_d  = 1'b0;
        unique case (state_q)
            StIdle: begin
                state_d = next_free;
                errp_d  = accept && reserved_req;
            end
            StT1: state_d = StT2;
            StT2: state_d = bus.READY ? StT3 : StTw;
            StTw: begin
                if (bus.READY) begin
                    state_d = StT3;
                end else if (timeout) begin
                    state_d = bus.HOLD ? StHold : StIdle;
                    errp_d  = 1'b1;
                end
            end
            StT3: begin
                if (is_of) begin
                    state_d = StT4;
                end else begin
                    state_d = next_free;
                    errp_d  = accept && reserved_req;
                end
            end
            StT4: begin
                state_d = next_free;
                errp_d  = accept && reserved_req;
            end
            StHold: state_d = bus.HOLD ? StHold : StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        bus.req_ready = can_accept;
        bus.done      = errp_q;
        bus.err       = errp_q;
        bus.rdata     = rdata_q;
        bus.HLDA      = 1'b0;
        bus.BUS_OE    = 1'b1;
        bus.ALE       = 1'b0;
        bus.RDn       = 1'b1;
        bus.WRn       = 1'b1;
        bus.IOMn      = iomn_q;
        bus.S1        = 1'b0;
        bus.S0        = 1'b0;
        bus.A_HI      = addr_q[AW-1:8];
        bus.AD_OUT    = 8'h00;
        bus.AD_OE     = 1'b0;
        if ((state_q == StT1) || (state_q == StT2) || (state_q == StTw) ||
            (state_q == StT3) || (state_q == StT4)) begin
            bus.S1 = is_rd;
            bus.S0 = is_of || is_wr;
        end
        unique case (state_q)
            StT1: begin
                bus.ALE    = 1'b1;
                bus.AD_OUT = addr_q[7:0];
                bus.AD_OE  = 1'b1;
            end
            StT2, StTw, StT3: begin
                bus.RDn = !is_rd;
                bus.WRn = !is_wr;
                if (is_wr) begin
                    bus.AD_OUT = wdata_q;
                    bus.AD_OE  = 1'b1;
                end
                if ((state_q == StT3) && !is_of) begin
                    bus.done = 1'b1;
                end
            end
            StT4: bus.done = 1'b1;
            StHold: begin
                bus.HLDA   = 1'b1;
                bus.BUS_OE = 1'b0;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_bus_cycle_ctrl.sv
// Directed + randomized bench for bus_cycle_ctrl; expected pin activity is derived
// per machine cycle from a phase list built from the bus-cycle rules.
module tb_bus_cycle_ctrl;
    localparam int unsigned AW = 16;
    localparam int MW = 15;
    localparam int PhT1 = 1, PhT2 = 2, PhTw = 3, PhT3 = 4, PhT4 = 5, PhAb = 6;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    bus_cycle_ctrl_if #(.AW(AW)) bus ();
    bus_cycle_ctrl #(.MAX_WAIT(MW), .AW(AW)) dut (.clk(clk), .rst(rst), .bus(bus));

    int checks = 0;
    int failures = 0;
    logic [7:0] last_rd = 8'h00;
    int n_t;
    logic [15:0] n_a;
    logic [7:0] n_wd;
    bit hold_t2 = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic bit rd_type(input int t);
        return (t == 0) || (t == 1) || (t == 3);
    endfunction

    function automatic bit wr_type(input int t);
        return (t == 2) || (t == 4);
    endfunction

    // {IOMn, S1, S0} per cycle type.
    function automatic logic [2:0] status(input int t);
        case (t)
            0: return 3'b011;
            1: return 3'b010;
            2: return 3'b001;
            3: return 3'b110;
            4: return 3'b101;
            default: return 3'b000;
        endcase
    endfunction

    task automatic drive_req(input int t, input logic [15:0] a, input logic [7:0] wd);
        bus.req_valid = 1'b1;
        bus.req_type  = 3'(t);
        bus.req_addr  = a;
        bus.req_wdata = wd;
    endtask

    // Called just after a rising edge. pre=1 means the request was accepted at that edge.
    task automatic run_cycle(input int t, input logic [15:0] a, input logic [7:0] wd,
                             input int nw, input logic [7:0] rd, input bit pre, input bit chain);
        int ph[$];
        int lows;
        bit abort;
        logic [2:0] st;
        if (!pre) begin
            drive_req(t, a, wd);
            @(negedge clk);
            chk("req_ready_idle", bus.req_ready, 1'b1);
            @(posedge clk);
            #1;
        end
        bus.req_valid = 1'b0;
        if (t > 4) begin
            @(negedge clk);
            chk("rsv_done", bus.done, 1'b1);
            chk("rsv_err", bus.err, 1'b1);
            chk("rsv_ale", bus.ALE, 1'b0);
            chk("rsv_strobes", {bus.RDn, bus.WRn}, 2'b11);
            @(posedge clk);
            #1;
            @(negedge clk);
            chk("rsv_done_pulse", {bus.done, bus.err, bus.ALE}, 3'b000);
            @(posedge clk);
            #1;
            return;
        end
        abort = (nw >= MW);
        st = status(t);
        ph.push_back(PhT1);
        ph.push_back(PhT2);
        for (int i = 0; i < (abort ? MW : nw); i++) ph.push_back(PhTw);
        if (abort) ph.push_back(PhAb);
        else begin
            ph.push_back(PhT3);
            if (t == 0) ph.push_back(PhT4);
        end
        lows = nw;
        foreach (ph[k]) begin
            int p;
            bit last;
            bit strobe;
            p = ph[k];
            last = (k == ph.size() - 1);
            strobe = (p == PhT2) || (p == PhTw) || (p == PhT3);
            bus.READY = (lows == 0);
            bus.AD_IN = (p == PhT3) ? rd : ~rd;
            if ((p == PhT2) && hold_t2) bus.HOLD = 1'b1;
            if (last && chain) drive_req(n_t, n_a, n_wd);
            @(negedge clk);
            chk("ale", bus.ALE, p == PhT1);
            chk("rdn", bus.RDn, !(strobe && rd_type(t)));
            chk("wrn", bus.WRn, !(strobe && wr_type(t)));
            chk("status", {bus.IOMn, bus.S1, bus.S0}, (p == PhAb) ? {st[2], 2'b00} : st);
            chk("ad_oe", bus.AD_OE, (p == PhT1) || (strobe && wr_type(t)));
            if (p == PhT1) begin
                chk("a_hi", bus.A_HI, a[15:8]);
                chk("ad_addr", bus.AD_OUT, a[7:0]);
            end
            if (strobe && wr_type(t)) chk("ad_wdata", bus.AD_OUT, wd);
            chk("done", bus.done, (p == PhAb) || (p == PhT4) || ((p == PhT3) && (t != 0)));
            chk("err", bus.err, p == PhAb);
            chk("req_ready", bus.req_ready, last && !bus.HOLD);
            chk("hlda", {bus.HLDA, bus.BUS_OE}, 2'b01);
            if (((p == PhT2) || (p == PhTw)) && (lows > 0)) lows--;
            @(posedge clk);
            #1;
        end
        if (rd_type(t) && !abort) last_rd = rd;
        chk("rdata", bus.rdata, last_rd);
        bus.READY = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int c_t, c_nw;
        logic [15:0] c_a;
        logic [7:0] c_wd, c_rd;
        bit pre, chain;
        bus.req_valid = 1'b0;
        bus.req_type  = 3'd0;
        bus.req_addr  = '0;
        bus.req_wdata = 8'h00;
        bus.READY     = 1'b1;
        bus.HOLD      = 1'b0;
        bus.AD_IN     = 8'h00;

        // Reset state.
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        chk("rst_strobes", {bus.ALE, bus.RDn, bus.WRn, bus.IOMn, bus.S1, bus.S0}, 6'b011000);
        chk("rst_bus", {bus.A_HI, bus.AD_OUT, bus.AD_OE, bus.BUS_OE, bus.HLDA}, 19'b1_0);
        chk("rst_core", {bus.done, bus.err, bus.req_ready, bus.rdata}, 11'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("idle_ready", bus.req_ready, 1'b1);
        @(posedge clk);
        #1;

        // Directed: MR, OF followed back-to-back by MW, IOW with two waits, timeout.
        run_cycle(1, 16'h2050, 8'h00, 0, 8'hA5, 1'b0, 1'b0);
        n_t = 2; n_a = 16'h1000; n_wd = 8'h55;
        run_cycle(0, 16'h0000, 8'h00, 0, 8'h3E, 1'b0, 1'b1);
        run_cycle(2, 16'h1000, 8'h55, 0, 8'h00, 1'b1, 1'b0);
        run_cycle(4, 16'h0080, 8'h7F, 2, 8'h00, 1'b0, 1'b0);
        run_cycle(1, 16'h4321, 8'h00, 20, 8'h99, 1'b0, 1'b0);

        // HOLD raised in T2 of MR: cycle completes, then bus is granted.
        hold_t2 = 1'b1;
        run_cycle(1, 16'h2050, 8'h00, 0, 8'h5A, 1'b0, 1'b0);
        hold_t2 = 1'b0;
        drive_req(1, 16'h3344, 8'h00);
        repeat (2) begin
            @(negedge clk);
            chk("hold_grant", {bus.HLDA, bus.BUS_OE, bus.req_ready, bus.ALE, bus.AD_OE}, 5'b10000);
            @(posedge clk);
            #1;
        end
        bus.HOLD = 1'b0;
        @(negedge clk);
        chk("hold_still", bus.HLDA, 1'b1);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("hold_idle", {bus.HLDA, bus.BUS_OE, bus.ALE, bus.req_ready}, 4'b0101);
        @(posedge clk);
        #1;
        run_cycle(1, 16'h3344, 8'h00, 0, 8'hC3, 1'b1, 1'b0);

        // Reset in TW of MW aborts without done.
        drive_req(2, 16'h1234, 8'hAA);
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        bus.READY = 1'b0;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        rst = 1'b1;
        @(negedge clk);
        chk("tw_wrn", {bus.WRn, bus.AD_OE}, 2'b01);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("rst_abort", {bus.WRn, bus.AD_OE, bus.done, bus.err, bus.ALE}, 5'b10000);
        @(posedge clk);
        #1;
        rst = 1'b0;
        bus.READY = 1'b1;
        @(negedge clk);
        chk("post_rst", {bus.done, bus.req_ready, bus.rdata}, 10'b01_0000_0000);
        last_rd = 8'h00;
        @(posedge clk);
        #1;

        // Reserved type.
        run_cycle(6, 16'hBEEF, 8'h00, 0, 8'h00, 1'b0, 1'b0);

        // Randomized cycles, optionally chained back-to-back.
        c_t = $urandom_range(0, 4); c_a = 16'($urandom); c_wd = 8'($urandom);
        c_nw = $urandom_range(0, 3);
        pre = 1'b0;
        for (int i = 0; i < 40; i++) begin
            n_t  = ($urandom_range(0, 7) == 0) ? $urandom_range(5, 7) : $urandom_range(0, 4);
            n_a  = 16'($urandom);
            n_wd = 8'($urandom);
            c_rd = 8'($urandom);
            chain = ($urandom_range(0, 1) == 1) && (c_t <= 4) && (c_nw < MW) && (i < 39);
            run_cycle(c_t, c_a, c_wd, c_nw, c_rd, pre, chain);
            pre = chain;
            c_t = n_t; c_a = n_a; c_wd = n_wd;
            c_nw = ($urandom_range(0, 9) == 0) ? 20 : $urandom_range(0, 3);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
